riscv_cpu: RTL and testbench

RISCV_CPU -- requirements
Module: riscv_cpu

---
 rtl/riscv_cpu.sv | 259 +++++++++++++++++++++++++
 tb/tb_riscv_cpu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_cpu.sv
// riscv_cpu: 5-stage in-order RV32I subset pipeline (IF/ID/EX/MEM/WB).
// Supports add, sub, and, or, slt, addi, andi, ori, lw, sw, beq, bne.
// Every other encoding retires as a NOP.
// Instruction, data and register storage are internal arrays (IMemory,
// DMemory, Regs). Benches preload and inspect them hierarchically.
//
// Ports:
//   clock - system clock; all state changes on the rising edge
//   reset - synchronous, active-high; empties the pipeline, PC=0, Regs=0;
//           memories keep their contents
module riscv_cpu #(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input  logic clock,
    input  logic reset
);

    localparam int unsigned IAW = $clog2(IMEM_WORDS);
    localparam int unsigned DAW = $clog2(DMEM_WORDS);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
        OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE
    } op_e;

    // Unloaded instruction memory executes as NOPs.
    logic [31:0] IMemory [0:IMEM_WORDS-1] = '{default: NOP_INSN};
    logic [31:0] DMemory [0:DMEM_WORDS-1];
    logic [31:0] Regs    [0:31];

    // Pipeline state
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_ir_q, ifid_pc_q;
    op_e         idex_op_q;
    logic [31:0] idex_pc_q, idex_a_q, idex_b_q, idex_imm_q;
    logic [4:0]  idex_rs1_q, idex_rs2_q, idex_rd_q;
    op_e         exmem_op_q;
    logic [31:0] exmem_alu_q, exmem_sd_q;
    logic [4:0]  exmem_rd_q;
    logic [4:0]  memwb_rd_q;
    logic [31:0] memwb_val_q;

    // ------------------------------------------------------------------ ID
    logic [6:0]  id_opc, id_f7;
    logic [2:0]  id_f3;
    op_e         id_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm, id_a, id_b;
    logic [31:0] imm_i, imm_s, imm_b;

    assign id_opc = ifid_ir_q[6:0];
    assign id_f3  = ifid_ir_q[14:12];
    assign id_f7  = ifid_ir_q[31:25];
    assign imm_i  = {{20{ifid_ir_q[31]}}, ifid_ir_q[31:20]};
    assign imm_s  = {{20{ifid_ir_q[31]}}, ifid_ir_q[31:25], ifid_ir_q[11:7]};
    assign imm_b  = {{20{ifid_ir_q[31]}}, ifid_ir_q[7], ifid_ir_q[30:25],
                     ifid_ir_q[11:8], 1'b0};

    always_comb begin
        id_op = OP_NOP;
        case (id_opc)
            7'b0110011: begin
                if (id_f7 == 7'b0000000) begin
                    case (id_f3)
                        3'b000:  id_op = OP_ADD;
                        3'b111:  id_op = OP_AND;
                        3'b110:  id_op = OP_OR;
                        3'b010:  id_op = OP_SLT;
                        default: id_op = OP_NOP;
                    endcase
                end else if (id_f7 == 7'b0100000 && id_f3 == 3'b000) begin
                    id_op = OP_SUB;
                end
            end
            7'b0010011: begin
                case (id_f3)
                    3'b000:  id_op = OP_ADDI;
                    3'b111:  id_op = OP_ANDI;
                    3'b110:  id_op = OP_ORI;
                    default: id_op = OP_NOP;
                endcase
            end
            7'b0000011: if (id_f3 == 3'b010) id_op = OP_LW;
            7'b0100011: if (id_f3 == 3'b010) id_op = OP_SW;
            7'b1100011: begin
                if (id_f3 == 3'b000)      id_op = OP_BEQ;
                else if (id_f3 == 3'b001) id_op = OP_BNE;
            end
            default: id_op = OP_NOP;
        endcase
    end

    // Unused source/destination fields are forced to x0 so that they can
    // never trigger a stall, a forward or a write.
    always_comb begin
        id_rs1 = '0;
        id_rs2 = '0;
        id_rd  = '0;
        id_imm = '0;
        case (id_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                id_rs1 = ifid_ir_q[19:15];
                id_rs2 = ifid_ir_q[24:20];
                id_rd  = ifid_ir_q[11:7];
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
                id_rs1 = ifid_ir_q[19:15];
                id_rd  = ifid_ir_q[11:7];
                id_imm = imm_i;
            end
            OP_SW: begin
                id_rs1 = ifid_ir_q[19:15];
                id_rs2 = ifid_ir_q[24:20];
                id_imm = imm_s;
            end
            OP_BEQ, OP_BNE: begin
                id_rs1 = ifid_ir_q[19:15];
                id_rs2 = ifid_ir_q[24:20];
                id_imm = imm_b;
            end
            default: ;
        endcase
    end

    // Register read with same-cycle WB bypass. memwb_rd_q is 0 for
    // non-writing instructions, so a nonzero match always means a real write.
    assign id_a = (id_rs1 == 5'd0) ? '0 :
                  (memwb_rd_q == id_rs1) ? memwb_val_q : Regs[id_rs1];
    assign id_b = (id_rs2 == 5'd0) ? '0 :
                  (memwb_rd_q == id_rs2) ? memwb_val_q : Regs[id_rs2];

    logic load_use;
    assign load_use = (idex_op_q == OP_LW) && (idex_rd_q != 5'd0) &&
                      ((idex_rd_q == id_rs1) || (idex_rd_q == id_rs2));

    // ------------------------------------------------------------------ EX
    logic [31:0] fwd_a, fwd_b, ex_res, ex_target;
    logic        ex_take;

    always_comb begin
        if (idex_rs1_q != 5'd0 && idex_rs1_q == exmem_rd_q)
            fwd_a = exmem_alu_q;
        else if (idex_rs1_q != 5'd0 && idex_rs1_q == memwb_rd_q)
            fwd_a = memwb_val_q;
        else
            fwd_a = idex_a_q;

        if (idex_rs2_q != 5'd0 && idex_rs2_q == exmem_rd_q)
            fwd_b = exmem_alu_q;
        else if (idex_rs2_q != 5'd0 && idex_rs2_q == memwb_rd_q)
            fwd_b = memwb_val_q;
        else
            fwd_b = idex_b_q;
    end

    always_comb begin
        ex_res  = '0;
        ex_take = 1'b0;
        case (idex_op_q)
            OP_ADD:  ex_res = fwd_a + fwd_b;
            OP_SUB:  ex_res = fwd_a - fwd_b;
            OP_AND:  ex_res = fwd_a & fwd_b;
            OP_OR:   ex_res = fwd_a | fwd_b;
            OP_SLT:  ex_res = {31'd0, $signed(fwd_a) < $signed(fwd_b)};
            OP_ADDI, OP_LW, OP_SW: ex_res = fwd_a + idex_imm_q;
            OP_ANDI: ex_res = fwd_a & idex_imm_q;
            OP_ORI:  ex_res = fwd_a | idex_imm_q;
            OP_BEQ:  ex_take = (fwd_a == fwd_b);
            OP_BNE:  ex_take = (fwd_a != fwd_b);
            default: ;
        endcase
    end

    assign ex_target = idex_pc_q + idex_imm_q;

    // ----------------------------------------------------------------- MEM
    logic [DAW-1:0] dmem_idx;
    logic [31:0]    mem_rdata, wb_val;

    assign dmem_idx  = exmem_alu_q[DAW+1:2];
    assign mem_rdata = DMemory[dmem_idx];
    assign wb_val    = (exmem_op_q == OP_LW) ? mem_rdata : exmem_alu_q;

    // ------------------------------------------------------------------ IF
    logic [IAW-1:0] imem_idx;
    assign imem_idx = pc_q[IAW+1:2];

    // A taken branch outranks a load-use stall.
    always_comb begin
        if (ex_take)       pc_d = ex_target;
        else if (load_use) pc_d = pc_q;
        else               pc_d = pc_q + 32'd4;
    end

    // ------------------------------------------------------------ sequential
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= '0;
            ifid_ir_q   <= NOP_INSN;
            ifid_pc_q   <= '0;
            idex_op_q   <= OP_NOP;
            idex_pc_q   <= '0;
            idex_a_q    <= '0;
            idex_b_q    <= '0;
            idex_imm_q  <= '0;
            idex_rs1_q  <= '0;
            idex_rs2_q  <= '0;
            idex_rd_q   <= '0;
            exmem_op_q  <= OP_NOP;
            exmem_alu_q <= '0;
            exmem_sd_q  <= '0;
            exmem_rd_q  <= '0;
            memwb_rd_q  <= '0;
            memwb_val_q <= '0;
            for (int unsigned i = 0; i < 32; i++) Regs[i] <= '0;
        end else begin
            pc_q <= pc_d;

            if (ex_take) begin
                ifid_ir_q <= NOP_INSN;
            end else if (!load_use) begin
                ifid_ir_q <= IMemory[imem_idx];
                ifid_pc_q <= pc_q;
            end

            if (ex_take || load_use) begin
                idex_op_q  <= OP_NOP;
                idex_rs1_q <= '0;
                idex_rs2_q <= '0;
                idex_rd_q  <= '0;
                idex_imm_q <= '0;
            end else begin
                idex_op_q  <= id_op;
                idex_pc_q  <= ifid_pc_q;
                idex_a_q   <= id_a;
                idex_b_q   <= id_b;
                idex_imm_q <= id_imm;
                idex_rs1_q <= id_rs1;
                idex_rs2_q <= id_rs2;
                idex_rd_q  <= id_rd;
            end

            exmem_op_q  <= idex_op_q;
            exmem_alu_q <= ex_res;
            exmem_sd_q  <= fwd_b;
            exmem_rd_q  <= idex_rd_q;

            if (exmem_op_q == OP_SW) DMemory[dmem_idx] <= exmem_sd_q;

            memwb_rd_q  <= exmem_rd_q;
            memwb_val_q <= wb_val;

            if (memwb_rd_q != 5'd0) Regs[memwb_rd_q] <= memwb_val_q;
        end
    end

endmodule

// File: tb/tb_riscv_cpu.sv
// tb_riscv_cpu: self-checking bench for riscv_cpu.
// Directed programs come from a table of {program, data, expected} records.
// A few hand sequences cover pipeline timing and mid-run reset.
// Random programs are compared against a sequential instruction-set
// interpreter that executes one instruction at a time.
module tb_riscv_cpu;

    localparam int IW = 256;
    localparam int DW = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    riscv_cpu #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .clock(clock),
        .reset(reset)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------- encoders
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3,
                                        input int rd, input int rs1, input int rs2);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] i_t(input logic [6:0] opc, input logic [2:0] f3,
                                        input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], opc};
    endfunction
    function automatic logic [31:0] I_ADD(int rd, int a, int b); return r_t(7'h00, 3'b000, rd, a, b); endfunction
    function automatic logic [31:0] I_SUB(int rd, int a, int b); return r_t(7'h20, 3'b000, rd, a, b); endfunction
    function automatic logic [31:0] I_AND(int rd, int a, int b); return r_t(7'h00, 3'b111, rd, a, b); endfunction
    function automatic logic [31:0] I_OR (int rd, int a, int b); return r_t(7'h00, 3'b110, rd, a, b); endfunction
    function automatic logic [31:0] I_SLT(int rd, int a, int b); return r_t(7'h00, 3'b010, rd, a, b); endfunction
    function automatic logic [31:0] I_ADDI(int rd, int a, int imm); return i_t(7'h13, 3'b000, rd, a, imm); endfunction
    function automatic logic [31:0] I_ANDI(int rd, int a, int imm); return i_t(7'h13, 3'b111, rd, a, imm); endfunction
    function automatic logic [31:0] I_ORI (int rd, int a, int imm); return i_t(7'h13, 3'b110, rd, a, imm); endfunction
    function automatic logic [31:0] I_LW  (int rd, int a, int imm); return i_t(7'h03, 3'b010, rd, a, imm); endfunction
    function automatic logic [31:0] I_SW(int src, int a, int imm);
        return {imm[11:5], src[4:0], a[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] I_BR(logic [2:0] f3, int a, int b, int imm);
        return {imm[12], imm[10:5], b[4:0], a[4:0], f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // ------------------------------------------------- reference model
    logic [31:0] m_i [IW];
    logic [31:0] m_r [32];
    logic [31:0] m_d [DW];

    function automatic int didx(logic [31:0] addr);
        return int'((addr >> 2) % DW);
    endfunction

    // Executes the program one whole instruction at a time until the PC
    // leaves the first n words (branches are forward-only, so this ends).
    task automatic ref_run(input int n);
        logic [31:0] pc, ir, a, b, v, ii, is, ib, npc;
        bit wr;
        pc = 0;
        for (int s = 0; s < 5000 && pc < 32'(4 * n); s++) begin
            ir  = m_i[(pc >> 2) % IW];
            a   = m_r[ir[19:15]];
            b   = m_r[ir[24:20]];
            ii  = {{20{ir[31]}}, ir[31:20]};
            is  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            ib  = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            npc = pc + 4;
            wr  = 0;
            v   = 0;
            case (ir[6:0])
                7'b0110011: begin
                    wr = 1;
                    if (ir[31:25] == 7'h00 && ir[14:12] == 3'b000)      v = a + b;
                    else if (ir[31:25] == 7'h20 && ir[14:12] == 3'b000) v = a - b;
                    else if (ir[31:25] == 7'h00 && ir[14:12] == 3'b111) v = a & b;
                    else if (ir[31:25] == 7'h00 && ir[14:12] == 3'b110) v = a | b;
                    else if (ir[31:25] == 7'h00 && ir[14:12] == 3'b010) v = ($signed(a) < $signed(b)) ? 1 : 0;
                    else wr = 0;
                end
                7'b0010011: begin
                    wr = 1;
                    if (ir[14:12] == 3'b000)      v = a + ii;
                    else if (ir[14:12] == 3'b111) v = a & ii;
                    else if (ir[14:12] == 3'b110) v = a | ii;
                    else wr = 0;
                end
                7'b0000011: if (ir[14:12] == 3'b010) begin wr = 1; v = m_d[didx(a + ii)]; end
                7'b0100011: if (ir[14:12] == 3'b010) m_d[didx(a + is)] = b;
                7'b1100011: begin
                    if (ir[14:12] == 3'b000 && a == b) npc = pc + ib;
                    if (ir[14:12] == 3'b001 && a != b) npc = pc + ib;
                end
                default: ;
            endcase
            if (wr && ir[11:7] != 0) m_r[ir[11:7]] = v;
            pc = npc;
        end
    endtask

    // ------------------------------------------------------ bench helpers
    task automatic start();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < IW; i++) dut.IMemory[i] = m_i[i];
        for (int i = 0; i < DW; i++) dut.DMemory[i] = m_d[i];
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < IW; i++) m_i[i] = NOP;
        for (int i = 0; i < DW; i++) m_d[i] = '0;
        for (int i = 0; i < 32; i++) m_r[i] = '0;
    endtask

    task automatic compare_all(input string tag);
        for (int r = 0; r < 32; r++) check($sformatf("%s x%0d", tag, r), dut.Regs[r], m_r[r]);
        for (int d = 0; d < DW; d++) check($sformatf("%s dmem[%0d]", tag, d), dut.DMemory[d], m_d[d]);
    endtask

    function automatic int rr();
        return int'($urandom_range(0, 7));
    endfunction

    // restricted: no branches, loads only from words 32..63, stores only to 0..31
    function automatic logic [31:0] gen(input bit restricted);
        int k, imm;
        k   = int'($urandom_range(0, restricted ? 10 : 12));
        imm = int'($urandom_range(0, 4095)) - 2048;
        case (k)
            0: return I_ADD(rr(), rr(), rr());
            1: return I_SUB(rr(), rr(), rr());
            2: return I_AND(rr(), rr(), rr());
            3: return I_OR (rr(), rr(), rr());
            4: return I_SLT(rr(), rr(), rr());
            5: return I_ADDI(rr(), rr(), imm);
            6: return I_ANDI(rr(), rr(), imm);
            7: return I_ORI (rr(), rr(), imm);
            8: return restricted ? I_LW(rr(), 0, 4 * int'($urandom_range(32, 63)))
                                 : I_LW(rr(), rr(), imm);
            9: return restricted ? I_SW(rr(), 0, 4 * int'($urandom_range(0, 31)))
                                 : I_SW(rr(), rr(), imm);
            10: begin
                case ($urandom_range(0, 3))
                    0: return r_t(7'h01, 3'b000, rr(), rr(), rr());   // mul
                    1: return i_t(7'h13, 3'b001, rr(), rr(), 3);      // slli
                    2: return {imm[19:0], 5'(rr()), 7'b0110111};      // lui
                    default: return i_t(7'h03, 3'b000, rr(), rr(), 0); // lb
                endcase
            end
            11: return I_BR(3'b000, rr(), rr(), 4 * int'($urandom_range(1, 4)));
            default: return I_BR(3'b001, rr(), rr(), 4 * int'($urandom_range(1, 4)));
        endcase
    endfunction

    // ------------------------------------------------------ directed table
    typedef struct packed {
        logic [7:0][31:0] prog;
        logic [31:0]      d0, d1;
        logic [1:0]       nchk;
        logic [2:0]       is_mem;
        logic [2:0][5:0]  idx;
        logic [2:0][31:0] val;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic [31:0] x;

        // two loads, load-use stall into add, store of the sum
        v = '0; v.d0 = 5; v.d1 = 7;
        v.prog[0] = I_LW(1, 0, 0); v.prog[1] = I_LW(2, 0, 4);
        v.prog[2] = I_ADD(3, 1, 2); v.prog[3] = I_SW(3, 0, 8);
        v.nchk = 3; v.is_mem = 3'b010;
        v.idx[0] = 3; v.val[0] = 12; v.idx[1] = 2; v.val[1] = 12; v.idx[2] = 1; v.val[2] = 5;
        vecs.push_back(v);
        // EX/MEM and MEM/WB forwarding
        v = '0;
        v.prog[0] = I_ADDI(1, 0, 10); v.prog[1] = I_ADDI(2, 1, -3); v.prog[2] = I_SUB(3, 2, 1);
        v.nchk = 3;
        v.idx[0] = 2; v.val[0] = 7; v.idx[1] = 3; v.val[1] = 32'hFFFF_FFFD; v.idx[2] = 1; v.val[2] = 10;
        vecs.push_back(v);
        // taken beq flushes two younger instructions
        v = '0;
        v.prog[0] = I_ADDI(1, 0, 1); v.prog[1] = I_BR(3'b000, 1, 1, 12);
        v.prog[2] = I_ADDI(5, 0, 9); v.prog[3] = I_ADDI(6, 0, 9); v.prog[4] = I_ADDI(7, 0, 3);
        v.nchk = 3;
        v.idx[0] = 5; v.val[0] = 0; v.idx[1] = 6; v.val[1] = 0; v.idx[2] = 7; v.val[2] = 3;
        vecs.push_back(v);
        // not-taken bne
        v = '0;
        v.prog[0] = I_BR(3'b001, 0, 0, 8); v.prog[1] = I_ADDI(4, 0, 2);
        v.nchk = 1; v.idx[0] = 4; v.val[0] = 2;
        vecs.push_back(v);
        // x0 never written, never forwarded
        v = '0;
        v.prog[0] = I_ADDI(8, 0, 9); v.prog[1] = I_ADDI(0, 0, 5); v.prog[2] = I_ADD(8, 0, 0);
        v.nchk = 2; v.idx[0] = 0; v.val[0] = 0; v.idx[1] = 8; v.val[1] = 0;
        vecs.push_back(v);
        // store then load of the same word
        v = '0;
        v.prog[0] = I_ADDI(1, 0, 33); v.prog[1] = I_SW(1, 0, 12);
        v.prog[2] = I_LW(2, 0, 12); v.prog[3] = I_ADD(3, 2, 2);
        v.nchk = 3; v.is_mem = 3'b100;
        v.idx[0] = 2; v.val[0] = 33; v.idx[1] = 3; v.val[1] = 66; v.idx[2] = 3; v.val[2] = 33;
        vecs.push_back(v);
        // signed slt, and
        v = '0;
        v.prog[0] = I_ADDI(1, 0, -5); v.prog[1] = I_ADDI(2, 0, 3);
        v.prog[2] = I_SLT(3, 1, 2); v.prog[3] = I_SLT(4, 2, 1); v.prog[4] = I_AND(6, 1, 2);
        v.nchk = 3;
        v.idx[0] = 3; v.val[0] = 1; v.idx[1] = 4; v.val[1] = 0; v.idx[2] = 6; v.val[2] = 3;
        vecs.push_back(v);
        // unsupported funct7 is a NOP; ori after it
        v = '0;
        v.prog[0] = I_ADDI(1, 0, 6); v.prog[1] = r_t(7'h01, 3'b000, 2, 1, 1); v.prog[2] = I_ORI(3, 1, 9);
        v.nchk = 2; v.idx[0] = 2; v.val[0] = 0; v.idx[1] = 3; v.val[1] = 15;
        vecs.push_back(v);

        foreach (vecs[t]) begin
            clear_model();
            for (int k = 0; k < 8; k++) if (vecs[t].prog[k] != 0) m_i[k] = vecs[t].prog[k];
            m_d[0] = vecs[t].d0;
            m_d[1] = vecs[t].d1;
            start();
            repeat (30) @(negedge clock);
            for (int c = 0; c < int'(vecs[t].nchk); c++) begin
                x = vecs[t].is_mem[c] ? dut.DMemory[vecs[t].idx[c]] : dut.Regs[vecs[t].idx[c]];
                check($sformatf("vec%0d %s[%0d]", t, vecs[t].is_mem[c] ? "dmem" : "x",
                      vecs[t].idx[c]), x, vecs[t].val[c]);
            end
        end

        // load-use stall holds the PC for exactly one cycle
        clear_model();
        m_i[0] = I_LW(1, 0, 0); m_i[1] = I_ADD(2, 1, 1); m_d[0] = 21;
        start();
        check("pc at reset", dut.pc_q, 32'd0);
        @(negedge clock);
        check("first fetch pc", dut.pc_q, 32'd4);
        check("first fetch insn", dut.ifid_ir_q, m_i[0]);
        repeat (3) @(negedge clock);
        check("load-use pc", dut.pc_q, 32'd12);
        repeat (10) @(negedge clock);
        check("load-use x2", dut.Regs[2], 32'd42);

        // taken branch redirects in EX, fourth edge after reset
        clear_model();
        m_i[1] = I_BR(3'b000, 0, 0, 16);
        start();
        repeat (4) @(negedge clock);
        check("branch redirect pc", dut.pc_q, 32'd20);

        // random programs versus the interpreter
        for (int p = 0; p < 25; p++) begin
            clear_model();
            for (int k = 0; k < 24; k++) m_i[k] = gen(1'b0);
            for (int d = 0; d < DW; d++) m_d[d] = $urandom;
            start();
            ref_run(24);
            repeat (100) @(negedge clock);
            compare_all($sformatf("rand%0d", p));
        end

        // reset in the middle of a run; stores only touch words 0..31 and
        // loads only read 32..63, so a full rerun gives the interpreter's result
        clear_model();
        for (int k = 0; k < 64; k++) m_i[k] = gen(1'b1);
        for (int d = 0; d < DW; d++) m_d[d] = $urandom;
        start();
        repeat (50) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("mid reset pc", dut.pc_q, 32'd0);
        for (int r = 0; r < 32; r++) check($sformatf("mid reset x%0d", r), dut.Regs[r], 32'd0);
        for (int d = 32; d < DW; d++) check($sformatf("mid reset dmem[%0d]", d), dut.DMemory[d], m_d[d]);
        reset = 1'b0;
        @(negedge clock);
        check("restart pc", dut.pc_q, 32'd4);
        check("restart insn", dut.ifid_ir_q, m_i[0]);
        ref_run(64);
        repeat (200) @(negedge clock);
        compare_all("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
